serial_adder: RTL

- Bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Uses a single one-bit full-adder cell and a carry flip-flop.
- Companion arithmetic block in the add/subtract library, sized for area-constrained datapaths where latency is acceptable.
- Exposes a start/busy/done handshake to the controlling sequencer.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract family: control state
// encoding and parameter legality helpers.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SA_WIDTH_MIN = 1;
  localparam int SA_WIDTH_MAX = 32;

  function automatic bit sa_width_legal(input int w);
    return (w >= SA_WIDTH_MIN) && (w <= SA_WIDTH_MAX);
  endfunction

  // Bit counter must index 0..w-1; a one-bit operand still needs one bit.
  function automatic int sa_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used for the per-bit step of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with a
// start/busy/done handshake and results held until the next accepted start.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (!sa_width_legal(WIDTH)) begin : g_width_check
    $error("serial_adder: WIDTH must be within 1..32");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH:0]   res_shift;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
  assign res_shift = {fa_sum, res_q};

  // Next-state, datapath and registered-output decode for the control FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          res_d   = {WIDTH{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1'b1;
        b_sr_d  = b_sr_q >> 1'b1;
        carry_d = fa_cout;
        res_d   = res_shift[WIDTH:1];
        // Counter holds on the final bit so it never wraps for WIDTH=2^k.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = res_shift[WIDTH:1];
          cout_d  = fa_cout;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      a_sr_q  <= {WIDTH{1'b0}};
      b_sr_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
